// File: rtl/mdc_pkg.sv
// Shared definitions for the coffee machine brew sequencer: state encoding,
// front-panel status codes, coin credit values and the phase timer width.
package mdc_pkg;

    localparam int CREDIT_W = 3;
    localparam int TMR_W    = 4;

    localparam logic [CREDIT_W-1:0] COIN5  = 3'd1;
    localparam logic [CREDIT_W-1:0] COIN10 = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CREDIT = 3'd1,
        ST_GRIND  = 3'd2,
        ST_HEAT   = 3'd3,
        ST_POUR   = 3'd4,
        ST_DONE   = 3'd5,
        ST_REFUND = 3'd6
    } state_e;

    localparam logic [2:0] OUT_IDLE   = 3'b000;
    localparam logic [2:0] OUT_CREDIT = 3'b001;
    localparam logic [2:0] OUT_BREW   = 3'b010;
    localparam logic [2:0] OUT_DONE   = 3'b011;
    localparam logic [2:0] OUT_REFUND = 3'b100;

    // Credit value of one coin given its type bit.
    function automatic logic [CREDIT_W-1:0] coin_value(input logic tm);
        return tm ? COIN10 : COIN5;
    endfunction

    // Front-panel status code shown for a given controller state.
    function automatic logic [2:0] status_code(input state_e st);
        logic [2:0] code;
        case (st)
            ST_IDLE:   code = OUT_IDLE;
            ST_CREDIT: code = OUT_CREDIT;
            ST_GRIND:  code = OUT_BREW;
            ST_HEAT:   code = OUT_BREW;
            ST_POUR:   code = OUT_BREW;
            ST_DONE:   code = OUT_DONE;
            ST_REFUND: code = OUT_REFUND;
            default:   code = OUT_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mdc_phase_timer.sv
// Loadable down-counter shared by the grind, heat and pour phases.
// A load sets the count to (N-1); zero rises once the count has run out.
module mdc_phase_timer
    import mdc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] value,
    output logic             zero
);

    logic [TMR_W-1:0] cnt_r;

    // Load on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {TMR_W{1'b0}};
        end else if (load) begin
            cnt_r <= value;
        end else if (cnt_r != {TMR_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(TMR_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {TMR_W{1'b0}});

endmodule

// File: rtl/mdc_brew_sequencer.sv
// Coffee machine controller: collects coin credit, checks water/coffee on the
// drink button, runs grinder, heater and pump for fixed cycle counts, and
// returns credit that cannot be used.
// Optional feature: define MDC_CREDIT_TIMEOUT_EN to refund credit after
// TIMEOUT_CYC cycles without coin or button activity in the CREDIT state.
module mdc_brew_sequencer
    import mdc_pkg::*;
#(
    parameter int PRICE       = 2,
    parameter int CREDIT_MAX  = 7,
    parameter int GRIND_CYC   = 4,
    parameter int HEAT_CYC    = 6,
    parameter int POUR_CYC    = 8
`ifdef MDC_CREDIT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hm,
    input  logic                tm,
    input  logic                ha,
    input  logic                hc,
    input  logic                bp,
    input  logic                bb,
    output logic                grind_on,
    output logic                heat_on,
    output logic                pump_on,
    output logic                refund,
    output logic [CREDIT_W-1:0] refund_amt,
    output logic [CREDIT_W-1:0] credit,
    output logic [2:0]          out
);

    localparam int GRIND_M1 = GRIND_CYC - 1;
    localparam int HEAT_M1  = HEAT_CYC - 1;
    localparam int POUR_M1  = POUR_CYC - 1;

    localparam logic [CREDIT_W-1:0] PRICE_V  = PRICE[CREDIT_W-1:0];
    localparam logic [CREDIT_W:0]   MAX_V    = CREDIT_MAX[CREDIT_W:0];
    localparam logic [TMR_W-1:0]    GRIND_LD = GRIND_M1[TMR_W-1:0];
    localparam logic [TMR_W-1:0]    HEAT_LD  = HEAT_M1[TMR_W-1:0];
    localparam logic [TMR_W-1:0]    POUR_LD  = POUR_M1[TMR_W-1:0];

    state_e              state_r;
    state_e              state_next_s;
    logic [CREDIT_W-1:0] credit_r;
    logic [CREDIT_W-1:0] credit_next_s;
    logic [CREDIT_W-1:0] credit_eff_s;
    logic [CREDIT_W-1:0] coin_val_s;
    logic [CREDIT_W:0]   sum_s;
    logic                hm_q_r;
    logic                bp_q_r;
    logic                coin_edge_s;
    logic                bp_edge_s;
    logic                coin_over_s;
    logic                coin_ref_s;
    logic                brew_ok_s;
    logic                timeout_s;
    logic                tmr_load_s;
    logic [TMR_W-1:0]    tmr_val_s;
    logic                tmr_zero_s;

    logic                grind_on_r;
    logic                heat_on_r;
    logic                pump_on_r;
    logic                refund_r;
    logic [CREDIT_W-1:0] refund_amt_r;
    logic [2:0]          out_r;

    mdc_phase_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load_s),
        .value (tmr_val_s),
        .zero  (tmr_zero_s)
    );

`ifdef MDC_CREDIT_TIMEOUT_EN
    localparam int IDLE_W  = $clog2(TIMEOUT_CYC) + 1;
    localparam int IDLE_M1 = TIMEOUT_CYC - 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_M1[IDLE_W-1:0];

    logic [IDLE_W-1:0] idle_cnt_r;

    // Count consecutive CREDIT cycles with no coin or button activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_r <= {IDLE_W{1'b0}};
        end else if ((state_r == ST_CREDIT) && !coin_edge_s && !bp_edge_s) begin
            idle_cnt_r <= idle_cnt_r + {{(IDLE_W-1){1'b0}}, 1'b1};
        end else begin
            idle_cnt_r <= {IDLE_W{1'b0}};
        end
    end

    assign timeout_s = (state_r == ST_CREDIT) && !coin_edge_s && !bp_edge_s &&
                       (idle_cnt_r == IDLE_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // Edge detectors: registered copies of the coin and button levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hm_q_r <= 1'b0;
            bp_q_r <= 1'b0;
        end else begin
            hm_q_r <= hm;
            bp_q_r <= bp;
        end
    end

    // Coin arithmetic: a coin that would push credit past the maximum is handed back.
    always_comb begin
        coin_edge_s  = hm & ~hm_q_r;
        bp_edge_s    = bp & ~bp_q_r;
        coin_val_s   = coin_value(tm);
        sum_s        = {1'b0, credit_r} + {1'b0, coin_val_s};
        coin_over_s  = coin_edge_s && (sum_s > MAX_V);
        if (coin_edge_s && !coin_over_s) begin
            credit_eff_s = sum_s[CREDIT_W-1:0];
        end else begin
            credit_eff_s = credit_r;
        end
        brew_ok_s    = (credit_eff_s >= PRICE_V) && ha && (hc || bb);
    end

    // Next-state, next-credit, timer load and coin-return decisions.
    always_comb begin
        state_next_s  = state_r;
        credit_next_s = credit_r;
        coin_ref_s    = 1'b0;
        tmr_load_s    = 1'b0;
        tmr_val_s     = {TMR_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (coin_edge_s) begin
                    credit_next_s = coin_val_s;
                    state_next_s  = ST_CREDIT;
                end else begin
                    state_next_s  = ST_IDLE;
                end
            end
            ST_CREDIT: begin
                coin_ref_s    = coin_over_s;
                credit_next_s = credit_eff_s;
                if (bp_edge_s) begin
                    if (brew_ok_s && bb) begin
                        state_next_s = ST_HEAT;
                        tmr_load_s   = 1'b1;
                        tmr_val_s    = HEAT_LD;
                    end else if (brew_ok_s) begin
                        state_next_s = ST_GRIND;
                        tmr_load_s   = 1'b1;
                        tmr_val_s    = GRIND_LD;
                    end else begin
                        state_next_s = ST_REFUND;
                    end
                end else if (timeout_s) begin
                    state_next_s = ST_REFUND;
                end else begin
                    state_next_s = ST_CREDIT;
                end
            end
            ST_GRIND: begin
                coin_ref_s = coin_edge_s;
                if (tmr_zero_s) begin
                    state_next_s = ST_HEAT;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = HEAT_LD;
                end else begin
                    state_next_s = ST_GRIND;
                end
            end
            ST_HEAT: begin
                coin_ref_s = coin_edge_s;
                if (!ha) begin
                    state_next_s = ST_REFUND;
                end else if (tmr_zero_s) begin
                    state_next_s = ST_POUR;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = POUR_LD;
                end else begin
                    state_next_s = ST_HEAT;
                end
            end
            ST_POUR: begin
                coin_ref_s = coin_edge_s;
                if (!ha) begin
                    state_next_s = ST_REFUND;
                end else if (tmr_zero_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_POUR;
                end
            end
            ST_DONE: begin
                coin_ref_s    = coin_edge_s;
                credit_next_s = credit_r - PRICE_V;
                if (credit_r != PRICE_V) begin
                    state_next_s = ST_REFUND;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REFUND: begin
                // A coin landing while the old credit is returned starts a new session.
                if (coin_edge_s) begin
                    credit_next_s = coin_val_s;
                    state_next_s  = ST_CREDIT;
                end else begin
                    credit_next_s = {CREDIT_W{1'b0}};
                    state_next_s  = ST_IDLE;
                end
            end
            default: begin
                credit_next_s = {CREDIT_W{1'b0}};
                state_next_s  = ST_IDLE;
            end
        endcase
    end

    // State and credit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            credit_r <= {CREDIT_W{1'b0}};
        end else begin
            state_r  <= state_next_s;
            credit_r <= credit_next_s;
        end
    end

    // Registered Moore outputs, one cycle behind the state they reflect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grind_on_r   <= 1'b0;
            heat_on_r    <= 1'b0;
            pump_on_r    <= 1'b0;
            refund_r     <= 1'b0;
            refund_amt_r <= {CREDIT_W{1'b0}};
            out_r        <= OUT_IDLE;
        end else begin
            grind_on_r <= (state_r == ST_GRIND);
            heat_on_r  <= (state_r == ST_HEAT);
            pump_on_r  <= (state_r == ST_POUR);
            out_r      <= status_code(state_r);
            if (state_r == ST_REFUND) begin
                refund_r     <= 1'b1;
                refund_amt_r <= credit_r;
            end else if (coin_ref_s) begin
                refund_r     <= 1'b1;
                refund_amt_r <= coin_val_s;
            end else begin
                refund_r     <= 1'b0;
                refund_amt_r <= {CREDIT_W{1'b0}};
            end
        end
    end

    assign grind_on   = grind_on_r;
    assign heat_on    = heat_on_r;
    assign pump_on    = pump_on_r;
    assign refund     = refund_r;
    assign refund_amt = refund_amt_r;
    assign credit     = credit_r;
    assign out        = out_r;

endmodule

// File: tb/tb_mdc_brew_sequencer.sv
// Self-checking bench for mdc_brew_sequencer: directed drink scenarios with
// hand-computed results, then randomized inputs checked every cycle against a
// schedule-based model of the machine.
module tb_mdc_brew_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hm = 1'b0, tm = 1'b0, ha = 1'b0, hc = 1'b0, bp = 1'b0, bb = 1'b0;
    logic       grind_on, heat_on, pump_on, refund;
    logic [2:0] refund_amt, credit, out;

    mdc_brew_sequencer dut (
        .clk(clk), .rst(rst), .hm(hm), .tm(tm), .ha(ha), .hc(hc), .bp(bp), .bb(bb),
        .grind_on(grind_on), .heat_on(heat_on), .pump_on(pump_on),
        .refund(refund), .refund_amt(refund_amt), .credit(credit), .out(out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model: phase letter I,C,G,H,P,D,R plus a queue of upcoming brew phases
    byte ph;
    byte sched[$];
    int  m_credit;
    bit  m_hm, m_bp;
    int  m_idle;
    bit  e_grind, e_heat, e_pump, e_ref;
    int  e_amt, e_out;

    // observed-output tallies for the literal checks
    int cnt_g, cnt_h, cnt_p, cnt_done, n_ref, last_amt;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr();
        cnt_g = 0; cnt_h = 0; cnt_p = 0; cnt_done = 0; n_ref = 0; last_amt = -1;
    endtask

    task automatic model_reset();
        ph = "I"; sched.delete(); m_credit = 0; m_hm = 0; m_bp = 0; m_idle = 0;
        e_grind = 0; e_heat = 0; e_pump = 0; e_ref = 0; e_amt = 0; e_out = 0;
    endtask

    // What the machine does at the next rising edge, given the current inputs.
    task automatic model_step();
        bit ce, be, back;
        int cv;
        ce = hm && !m_hm;
        be = bp && !m_bp;
        cv = tm ? 2 : 1;
        m_hm = hm; m_bp = bp;
        back = 0;
        if (ce) begin
            if (ph == "G" || ph == "H" || ph == "P" || ph == "D") back = 1;
            else if (ph == "C" && m_credit + cv > 7) back = 1;
        end
        e_grind = (ph == "G");
        e_heat  = (ph == "H");
        e_pump  = (ph == "P");
        if (ph == "C") e_out = 1;
        else if (ph == "G" || ph == "H" || ph == "P") e_out = 2;
        else if (ph == "D") e_out = 3;
        else if (ph == "R") e_out = 4;
        else e_out = 0;
        if (ph == "R") begin e_ref = 1; e_amt = m_credit; end
        else if (back) begin e_ref = 1; e_amt = cv; end
        else begin e_ref = 0; e_amt = 0; end

        if (ph == "I") begin
            if (ce) begin m_credit = cv; ph = "C"; m_idle = 0; end
        end else if (ph == "C") begin
            if (ce && !back) m_credit += cv;
            if (be) begin
                if (m_credit >= 2 && ha && (hc || bb)) begin
                    sched.delete();
                    if (!bb) repeat (4) sched.push_back("G");
                    repeat (6) sched.push_back("H");
                    repeat (8) sched.push_back("P");
                    sched.push_back("D");
                    ph = sched.pop_front();
                end else begin
                    ph = "R";
                end
            end else if (ce) begin
                m_idle = 0;
            end else begin
                m_idle++;
`ifdef MDC_CREDIT_TIMEOUT_EN
                if (m_idle == 32) ph = "R";
`endif
            end
        end else if (ph == "G" || ph == "H" || ph == "P") begin
            if ((ph == "H" || ph == "P") && !ha) begin
                sched.delete();
                ph = "R";
            end else begin
                ph = sched.pop_front();
            end
        end else if (ph == "D") begin
            m_credit -= 2;
            ph = (m_credit != 0) ? "R" : "I";
        end else begin
            if (ce) begin m_credit = cv; ph = "C"; m_idle = 0; end
            else begin m_credit = 0; ph = "I"; end
        end
    endtask

    // One clock: apply inputs, advance model, compare every output.
    task automatic cycle(input bit h, input bit t, input bit a, input bit c,
                         input bit p, input bit b);
        hm = h; tm = t; ha = a; hc = c; bp = p; bb = b;
        model_step();
        @(negedge clk);
        chk("grind_on", grind_on, e_grind);
        chk("heat_on", heat_on, e_heat);
        chk("pump_on", pump_on, e_pump);
        chk("refund", refund, e_ref);
        chk("refund_amt", refund_amt, e_amt);
        chk("credit", credit, m_credit);
        chk("out", out, e_out);
        cnt_g += grind_on; cnt_h += heat_on; cnt_p += pump_on;
        if (out == 3'b011) cnt_done++;
        if (refund) begin n_ref++; last_amt = refund_amt; end
    endtask

    task automatic idle(input int n, input bit a);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, a, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic coin(input bit t);
        cycle(1'b1, t, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b1);
    endtask

    task automatic press(input bit c, input bit b);
        cycle(1'b0, 1'b0, 1'b1, c, 1'b1, b);
        cycle(1'b0, 1'b0, 1'b1, c, 1'b0, b);
    endtask

    // Asynchronous reset between clock edges; outputs must clear immediately.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        hm = 0; tm = 0; ha = 0; hc = 0; bp = 0; bb = 0;
        #1;
        chk("rst_grind", grind_on, 0);
        chk("rst_heat", heat_on, 0);
        chk("rst_pump", pump_on, 0);
        chk("rst_refund", refund, 0);
        chk("rst_amt", refund_amt, 0);
        chk("rst_credit", credit, 0);
        chk("rst_out", out, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        clr();
        do_reset();

        // coffee with a 10-coin: 4/6/8 actuator cycles, done once, nothing returned
        coin(1'b1);
        press(1'b1, 1'b0);
        idle(24, 1'b1);
        chk("t2_grind_cycles", cnt_g, 4);
        chk("t2_heat_cycles", cnt_h, 6);
        chk("t2_pump_cycles", cnt_p, 8);
        chk("t2_done_cycles", cnt_done, 1);
        chk("t2_refunds", n_ref, 0);
        chk("t2_credit_end", credit, 0);
        chk("t2_out_end", out, 0);

        // not enough credit: one 5-coin is returned
        clr();
        coin(1'b0);
        press(1'b1, 1'b0);
        idle(3, 1'b1);
        chk("t3_refunds", n_ref, 1);
        chk("t3_amt", last_amt, 1);
        chk("t3_credit", credit, 0);

        // hot water without coffee, credit 4: no grind, change of 2
        clr();
        coin(1'b1);
        coin(1'b1);
        press(1'b0, 1'b1);
        idle(22, 1'b1);
        chk("t4_grind_cycles", cnt_g, 0);
        chk("t4_heat_cycles", cnt_h, 6);
        chk("t4_pump_cycles", cnt_p, 8);
        chk("t4_amt", last_amt, 2);
        chk("t4_refunds", n_ref, 1);

        // saturation: credit 6 plus a 10-coin returns the coin, then ha abort
        coin(1'b1); coin(1'b1); coin(1'b1);
        clr();
        coin(1'b1);
        idle(1, 1'b1);
        chk("t5_over_refunds", n_ref, 1);
        chk("t5_over_amt", last_amt, 2);
        chk("t5_credit_kept", credit, 6);
        clr();
        press(1'b1, 1'b1);
        idle(3, 1'b1);
        idle(5, 1'b0);
        chk("t5_abort_amt", last_amt, 6);
        chk("t5_abort_refunds", n_ref, 1);
        chk("t5_pump_cycles", cnt_p, 0);
        chk("t5_credit_end", credit, 0);

        // coin and button on the same edge: 1 + 1 reaches the price
        clr();
        coin(1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(24, 1'b1);
        chk("t6_grind_cycles", cnt_g, 4);
        chk("t6_refunds", n_ref, 0);

`ifdef MDC_CREDIT_TIMEOUT_EN
        clr();
        coin(1'b0);
        idle(34, 1'b1);
        chk("t6_timeout_refunds", n_ref, 1);
        chk("t6_timeout_amt", last_amt, 1);
`endif

        // reset in the middle of pouring
        clr();
        coin(1'b1);
        press(1'b1, 1'b0);
        idle(13, 1'b1);
        chk("t1_pump_mid", pump_on, 1);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 29) != 0, $urandom_range(0, 7) != 0,
                      $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
